// File: rtl/smvm_pkg.sv
// smvm_seg shared types: FSM states, accumulator width, result conversion.
// SMVM_SAT_EN selects saturating instead of wrapping result conversion.
package smvm_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_VEC,
      S_MAT,
      S_DRAIN
   } state_t;

   function automatic int acc_width(input int val_w, input int col_w);
      return 2 * val_w + col_w + 1;
   endfunction

   function automatic logic signed [63:0] to_out(
      input logic signed [63:0] v,
      input int                 out_w
   );
`ifdef SMVM_SAT_EN
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
`else
      return (v <<< (64 - out_w)) >>> (64 - out_w);
`endif
   endfunction

endpackage

// File: rtl/smvm_seg_out_fifo.sv
// Result FIFO: up to K compacted writes and one read per cycle.
// Depth must be a power of two; o_free reports unused entries.
module smvm_out_fifo
   import smvm_pkg::*;
#(
   parameter int W     = 22,
   parameter int K     = 4,
   parameter int DEPTH = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [$clog2(K+1)-1:0]       i_wr_n,
   input  logic [K-1:0][W-1:0]          i_wdata,
   input  logic                         i_rd,
   output logic [W-1:0]                 o_rdata,
   output logic                         o_empty,
   output logic [$clog2(DEPTH+1)-1:0]   o_free
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_cnt;
   logic          w_rd;

   assign w_rd    = i_rd && (r_cnt != '0);
   assign o_empty = (r_cnt == '0);
   assign o_free  = CW'(DEPTH) - r_cnt;
   assign o_rdata = r_mem[r_rptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         r_wptr <= r_wptr + AW'(i_wr_n);
         if (w_rd) r_rptr <= r_rptr + 1'b1;
         r_cnt <= r_cnt + CW'(i_wr_n) - CW'(w_rd);
      end
   end

   always_ff @(posedge clk) begin
      for (int j = 0; j < K; j++) begin
         if (j < int'(i_wr_n)) r_mem[r_wptr + AW'(j)] <= i_wdata[j];
      end
   end

endmodule

// File: rtl/smvm_seg.sv
// Streaming k-lane sparse matrix-vector multiplier with segmented reduction.
// Define SMVM_SAT_EN to saturate row sums to OUT_W instead of wrapping.
module smvm_seg
   import smvm_pkg::*;
#(
   parameter int  K          = 4,
   parameter int  VAL_W      = 8,
   parameter int  MAX_COLS   = 512,
   parameter int  ROW_W      = 9,
   parameter int  OUT_W      = 13,
   parameter int  FIFO_DEPTH = 16,
   localparam int COL_W      = $clog2(MAX_COLS)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [COL_W:0]         cfg_cols,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [K*VAL_W-1:0]     in_val,
   input  logic [K*COL_W-1:0]     in_col,
   input  logic [K-1:0]           in_mask,
   input  logic [K-1:0]           in_last,
   input  logic                   in_end,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [OUT_W-1:0]       out_data,
   output logic [ROW_W-1:0]       out_row,
   output logic                   done
);

   localparam int ACC_W = acc_width(VAL_W, COL_W);
   localparam int P_W   = 2 * VAL_W;
   localparam int FCW   = $clog2(FIFO_DEPTH + 1);
   localparam int NW    = $clog2(K + 1);
   localparam int KA    = $clog2(K);
   localparam int E_W   = OUT_W + ROW_W;
   localparam logic [COL_W:0] MAXC = (COL_W + 1)'(MAX_COLS);

   state_t r_state;
   state_t w_next;

   logic [COL_W:0]           r_cols;
   logic [COL_W-1:0]         r_ptr;
   logic signed [VAL_W-1:0]  r_vec [MAX_COLS];

   logic                     w_beat;
   logic [K-1:0][P_W-1:0]    w_prod;

   logic                     r_v1;
   logic [K-1:0][P_W-1:0]    r_p1;
   logic [K-1:0]             r_m1;
   logic [K-1:0]             r_l1;
   logic                     r_e1;
   logic                     r_v2;
   logic [K-1:0][ACC_W-1:0]  r_p2;
   logic [K-1:0]             r_m2;
   logic [K-1:0]             r_l2;
   logic                     r_e2;

   logic signed [ACC_W-1:0]  r_carry;
   logic signed [ACC_W-1:0]  w_acc;
   logic                     r_open;
   logic                     w_open;
   logic [ROW_W-1:0]         r_row;
   logic [ROW_W-1:0]         w_row;
   logic [NW-1:0]            w_nw;
   logic [K-1:0][E_W-1:0]    w_wdata;

   logic [E_W-1:0]           w_rdata;
   logic                     w_empty;
   logic [FCW-1:0]           w_free;

   function automatic logic [OUT_W-1:0] f_out(
      input logic signed [ACC_W-1:0] a
   );
      logic signed [63:0] w_t;
      w_t = to_out(64'(a), OUT_W);
      return w_t[OUT_W-1:0];
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      in_ready = 1'b0;
      done     = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (start && cfg_cols != '0 && cfg_cols <= MAXC)
               w_next = S_VEC;
         end
         S_VEC: begin
            in_ready = 1'b1;
            if (in_valid && {1'b0, r_ptr} == r_cols - 1'b1)
               w_next = S_MAT;
         end
         S_MAT: begin
            in_ready = (w_free >= FCW'(3 * K));
            if (in_valid && in_ready && in_end)
               w_next = S_DRAIN;
         end
         S_DRAIN: begin
            if (!r_v1 && !r_v2 && w_empty) begin
               done   = 1'b1;
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cols <= '0;
         r_ptr  <= '0;
      end else if (r_state == S_IDLE && w_next == S_VEC) begin
         r_cols <= cfg_cols;
         r_ptr  <= '0;
      end else if (r_state == S_VEC && in_valid) begin
         r_ptr <= r_ptr + 1'b1;
      end
   end

   // Vector storage persists across jobs and is never reset.
   always_ff @(posedge clk) begin
      if (r_state == S_VEC && in_valid)
         r_vec[r_ptr] <= in_val[VAL_W-1:0];
   end

   assign w_beat = (r_state == S_MAT) && in_valid && in_ready;

   for (genvar g = 0; g < K; g++) begin : g_lane
      logic [COL_W-1:0]        w_col;
      logic signed [VAL_W-1:0] w_a;
      logic signed [VAL_W-1:0] w_b;
      assign w_col     = in_col[g*COL_W +: COL_W];
      assign w_a       = in_val[g*VAL_W +: VAL_W];
      assign w_b       = ({1'b0, w_col} < r_cols) ? r_vec[w_col] : '0;
      assign w_prod[g] = in_mask[g] ? P_W'(w_a * w_b) : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1 <= 1'b0;
         r_p1 <= '0;
         r_m1 <= '0;
         r_l1 <= '0;
         r_e1 <= 1'b0;
         r_v2 <= 1'b0;
         r_p2 <= '0;
         r_m2 <= '0;
         r_l2 <= '0;
         r_e2 <= 1'b0;
      end else begin
         r_v1 <= w_beat;
         r_p1 <= w_prod;
         r_m1 <= in_mask;
         r_l1 <= in_last & in_mask;
         r_e1 <= in_end;
         r_v2 <= r_v1;
         for (int i = 0; i < K; i++)
            r_p2[i] <= ACC_W'($signed(r_p1[i]));
         r_m2 <= r_m1;
         r_l2 <= r_l1;
         r_e2 <= r_e1;
      end
   end

   // Lane-ordered segmented scan; w_open marks a row still awaiting its end.
   always_comb begin
      w_acc   = r_carry;
      w_open  = r_open;
      w_row   = r_row;
      w_nw    = '0;
      w_wdata = '0;
      if (r_v2) begin
         for (int i = 0; i < K; i++) begin
            if (r_m2[i]) begin
               w_acc  = w_acc + $signed(r_p2[i]);
               w_open = 1'b1;
               if (r_l2[i]) begin
                  w_wdata[w_nw[KA-1:0]] = {f_out(w_acc), w_row};
                  w_nw   = w_nw + 1'b1;
                  w_row  = w_row + 1'b1;
                  w_acc  = '0;
                  w_open = 1'b0;
               end
            end
         end
         if (r_e2) begin
            if (w_open) begin
               w_wdata[w_nw[KA-1:0]] = {f_out(w_acc), w_row};
               w_nw  = w_nw + 1'b1;
               w_row = w_row + 1'b1;
            end
            w_acc  = '0;
            w_open = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_carry <= '0;
         r_open  <= 1'b0;
         r_row   <= '0;
      end else begin
         r_carry <= w_acc;
         r_open  <= w_open;
         r_row   <= (r_state == S_IDLE) ? '0 : w_row;
      end
   end

   smvm_out_fifo #(
      .W     (E_W),
      .K     (K),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_wr_n  (w_nw),
      .i_wdata (w_wdata),
      .i_rd    (out_ready),
      .o_rdata (w_rdata),
      .o_empty (w_empty),
      .o_free  (w_free)
   );

   assign out_valid = !w_empty;
   assign out_data  = w_empty ? '0 : w_rdata[E_W-1:ROW_W];
   assign out_row   = w_empty ? '0 : w_rdata[ROW_W-1:0];

endmodule

// File: tb/tb_smvm_seg.sv
// Directed scoreboard bench for smvm_seg.
// Expected row sums are queued as beats are driven and popped on output.
module tb_smvm_seg;

   localparam int K     = 4;
   localparam int VAL_W = 8;
   localparam int COL_W = 9;
   localparam int ROW_W = 9;
   localparam int OUT_W = 13;
   localparam int E_W   = OUT_W + ROW_W;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 start = 1'b0;
   logic [COL_W:0]       cfg_cols = '0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic [K*VAL_W-1:0]   in_val = '0;
   logic [K*COL_W-1:0]   in_col = '0;
   logic [K-1:0]         in_mask = '0;
   logic [K-1:0]         in_last = '0;
   logic                 in_end = 1'b0;
   logic                 out_valid;
   logic                 out_ready = 1'b1;
   logic [OUT_W-1:0]     out_data;
   logic [ROW_W-1:0]     out_row;
   logic                 done;

   int checks = 0;
   int failures = 0;
   int acc_cnt = 0;
   logic [E_W-1:0] sb[$];

   smvm_seg #(
      .K          (K),
      .VAL_W      (VAL_W),
      .MAX_COLS   (512),
      .ROW_W      (ROW_W),
      .OUT_W      (OUT_W),
      .FIFO_DEPTH (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .cfg_cols  (cfg_cols),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_val    (in_val),
      .in_col    (in_col),
      .in_mask   (in_mask),
      .in_last   (in_last),
      .in_end    (in_end),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_row   (out_row),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   always @(posedge clk) if (in_valid && in_ready) acc_cnt++;

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         checks++;
         assert (sb.size() > 0) else begin
            failures++;
            $error("FAIL unexpected_result: observed row=%0d data=%0d expected none",
                   out_row, out_data);
         end
         if (sb.size() > 0) begin
            logic [E_W-1:0] e;
            e = sb.pop_front();
            chk("out_data", 32'(out_data), 32'(e[E_W-1:ROW_W]));
            chk("out_row", 32'(out_row), 32'(e[ROW_W-1:0]));
         end
      end
   end

   function automatic logic [K*VAL_W-1:0] pv(input int a, b, c, d);
      return {VAL_W'(d), VAL_W'(c), VAL_W'(b), VAL_W'(a)};
   endfunction

   function automatic logic [K*COL_W-1:0] pc(input int a, b, c, d);
      return {COL_W'(d), COL_W'(c), COL_W'(b), COL_W'(a)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int data, input int row);
      sb.push_back({OUT_W'(data), ROW_W'(row)});
   endtask

   task automatic send(input logic [K*VAL_W-1:0] v,
                       input logic [K*COL_W-1:0] c,
                       input logic [K-1:0] m, input logic [K-1:0] l,
                       input logic e);
      int n = 0;
      in_valid = 1'b1;
      in_val   = v;
      in_col   = c;
      in_mask  = m;
      in_last  = l;
      in_end   = e;
      @(negedge clk);
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_end   = 1'b0;
   endtask

   task automatic start_job(input int cols);
      start    = 1'b1;
      cfg_cols = (COL_W + 1)'(cols);
      tick();
      start = 1'b0;
   endtask

   task automatic load1(input int v);
      send(pv(v, 0, 0, 0), '0, 4'b0001, 4'b0000, 1'b0);
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!done && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(done), 32'd1);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      tick();
   endtask

   initial begin
      int base;
      repeat (3) tick();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_row", 32'(out_row), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      rst_n = 1'b1;
      tick();

      // Job A: single row ending mid-beat, plus output latency
      start_job(3);
      load1(2);
      load1(3);
      load1(4);
      push(9, 0);
      send(pv(1, 1, 1, 0), pc(0, 1, 2, 0), 4'b0111, 4'b0100, 1'b1);
      @(negedge clk);
      chk("lat_t1", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("lat_t2", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("lat_t3", 32'(out_valid), 32'd1);
      wait_done("done_a");

      // zero-length start is ignored
      start_job(0);
      repeat (2) tick();
      chk("cols0_ignored", 32'(in_ready), 32'd0);

      // Job B: row spanning two beats
      start_job(1);
      load1(5);
      push(30, 0);
      send(pv(1, 1, 1, 1), '0, 4'b1111, 4'b0000, 1'b0);
      send(pv(1, 1, 0, 0), '0, 4'b0011, 4'b0010, 1'b1);
      wait_done("done_b");

      // Job C: four rows ending in one beat
      start_job(1);
      load1(2);
      push(2, 0);
      push(4, 1);
      push(6, 2);
      push(8, 3);
      send(pv(1, 2, 3, 4), '0, 4'b1111, 4'b1111, 1'b1);
      wait_done("done_c");

      // Job D: output backpressure while streaming ten beats
      start_job(1);
      load1(1);
      base = acc_cnt;
      out_ready = 1'b0;
      fork
         begin
            repeat (20) @(posedge clk);
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_accepted", 32'(acc_cnt - base), 32'd4);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            out_ready = 1'b1;
         end
      join_none
      for (int b = 0; b < 10; b++) begin
         for (int i = 0; i < K; i++) push(b * 4 + i + 1, b * 4 + i);
         send(pv(b * 4 + 1, b * 4 + 2, b * 4 + 3, b * 4 + 4), '0,
              4'b1111, 4'b1111, b == 9);
      end
      wait_done("done_d");

      // Job E: overflow conversion of residual row on in_end
      start_job(1);
      load1(127);
`ifdef SMVM_SAT_EN
      push(4095, 0);
`else
      push('h1C04, 0);
`endif
      send(pv(127, 127, 127, 127), '0, 4'b1111, 4'b0000, 1'b1);
      wait_done("done_e");

      // Job F: reset mid-MAT, then a fresh job
      start_job(1);
      load1(1);
      send(pv(1, 1, 1, 1), '0, 4'b1111, 4'b0000, 1'b0);
      tick();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_out_data", 32'(out_data), 32'd0);
      chk("mid_rst_out_row", 32'(out_row), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_sb", 32'(sb.size()), 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      start_job(1);
      load1(7);
      push(21, 0);
      send(pv(3, 9, 0, 0), pc(0, 2, 0, 0), 4'b0011, 4'b0010, 1'b1);
      wait_done("done_f");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/smvm_seg.md
# smvm_seg

Parametrised streaming sparse matrix-vector multiplier, next generation of the k-lane SMVM datapath. It loads a dense vector, then accepts K nonzeros per beat, each tagged with a column index and a row-end flag (IPV). It forms per-lane products and performs a segmented reduction across lanes and beats, so rows may span beats or several rows may end in one beat. Completed row sums enter an output FIFO drained over a valid/ready port. It sits between the nonzero-stream front end and the result writer.

## Interface
- K, 4, lanes (nonzeros per beat), power of two ≥2
- VAL_W, 8, signed vector/matrix element width
- MAX_COLS, 512, vector capacity; COL_W = $clog2(MAX_COLS)
- ROW_W, 9, row index width
- OUT_W, 13, signed result width
- FIFO_DEPTH, 16, output FIFO entries, must be ≥ 3*K
- clk  in  1  clock; all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  job start pulse, sampled only in IDLE
- cfg_cols  in  COL_W+1  vector length for the job, 1..MAX_COLS
- in_valid / in_ready  in / out  1  input beat handshake
- in_val  in  K*VAL_W  lane values (lane 0 in LSBs)
- in_col  in  K*COL_W  lane column indices (MAT only)
- in_mask  in  K  lane enables, contiguous from lane 0 (MAT only)
- in_last  in  K  per-lane row-end flag (IPV)
- in_end  in  1  final beat of the matrix
- out_valid / out_ready  out / in  1  result handshake
- out_data  out  OUT_W  row sum
- out_row  out  ROW_W  row index, from 0 per job
- done  out  1  one-cycle pulse at job end

## Operation
- FSM IDLE → VEC → MAT → DRAIN → IDLE.
- IDLE: in_ready=0. start with cfg_cols in 1..MAX_COLS latches cols and goes to VEC. start with cfg_cols=0 is ignored. start outside IDLE is ignored.
- VEC: in_ready=1. Each accepted beat writes lane 0 of in_val to vec[ptr], then ptr++. After cols beats → MAT. The vector is not cleared between jobs.
- MAT: each accepted beat, for each enabled lane i: p_i = val_i * vec[col_i] (signed, 2*VAL_W). col_i ≥ cols reads 0.
- Segmented reduction, lane order 0..K-1, starting from a carry register. Accumulate p_i. A lane with in_last set emits acc as a row result and resets acc to 0. The residual becomes the next carry.
- in_end beat: if the last enabled lane lacks in_last, the residual is emitted as a final row anyway. Carry then clears and state → DRAIN. A beat with mask=0 contributes nothing, but its in_end still counts.
- Empty rows are not representable. The producer sends an explicit zero nonzero.
- Results of one beat are written to the FIFO in lane order, with out_row incrementing per row. Up to K writes per cycle.
- Internal accumulator width ACC_W = 2*VAL_W + COL_W + 1, never overflows. Conversion to OUT_W is set by Configuration.
- in_ready in MAT = FIFO free slots ≥ 3*K. This covers the two in-flight beats, so the FIFO never overflows.
- DRAIN: in_ready=0. When pipeline and FIFO are empty, pulse done and go to IDLE.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, out_row=0, done=0, FSM=IDLE, carry=0, FIFO empty.
- Beat accepted in cycle t:
  - products registered at t+1;
  - reduction plus FIFO write at end of t+2;
  - first result out_valid in t+3 if the FIFO was empty.
- Throughput: one beat/cycle and one result/cycle out.
- out_data/out_row hold stable while out_valid && !out_ready.
- Simultaneous FIFO read and K writes in one cycle are allowed.
- Reset mid-job aborts immediately. Partial results are discarded and no done pulse is issued.

## Configuration
- SMVM_SAT_EN defined: ACC_W→OUT_W saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- SMVM_SAT_EN undefined: keep the low OUT_W bits (two's-complement wrap).

## Structure
- Package smvm_pkg: FSM state enum, ACC_W derivation, the saturate/wrap function.
- Sub-module smvm_out_fifo: K-write/1-read FIFO with free-slot count.

## Test plan
- K=4, cols=3, vec=[2,3,4]; one beat, mask=0111, vals=1,1,1, cols 0,1,2, last=0100, in_end → out_data=9, out_row=0, then done.
- vec[0]=5; 6 nonzeros val=1 col=0 over two beats, last on beat 2 lane 1, in_end → single result 30.
- vec[0]=2; one beat, mask=1111, vals 1,2,3,4, last=1111 → results 2,4,6,8 with out_row 0,1,2,3 in order.
- out_ready=0 for 20 cycles while streaming 10 full beats → in_ready drops at ≤11 free slots; all results delivered in order after release, none lost.
- vals 127×vec 127 on 4 lanes in one row (sum 64516) → 4095 with SMVM_SAT_EN; 0x1C04 (-1020) without.
- rst_n low mid-MAT → outputs at reset values, FSM IDLE; next job with cols=1, vec=[7], val 3 → result 21, row 0.
